// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM with registered read data.
// A write takes 2 cycles (IDLE, ISSUE). A read takes 3 cycles (IDLE, ISSUE, READ), with rvalid in the following IDLE.
module ram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ} state_t;

  state_t state;
  logic   sel_b;
  logic   last_b;
  logic   lat_we;
  logic   pick_b;

  // B wins when it is the only requester, or when both request and A was granted last.
  assign pick_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_b    <= 1'b0;
      last_b   <= 1'b1;
      lat_we   <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            sel_b    <= pick_b;
            last_b   <= pick_b;
            lat_we   <= pick_b ? b_we : a_we;
            ram_addr <= pick_b ? b_addr : a_addr;
            ram_din  <= pick_b ? b_wdata : a_wdata;
            ram_ena  <= 1'b1;
            ram_wena <= pick_b ? b_we : a_we;
            a_gnt    <= ~pick_b;
            b_gnt    <= pick_b;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= lat_we ? IDLE : READ;
        end
        READ: begin
          // The RAM presents read data this cycle; the capture and the rvalid pulse land together.
          if (sel_b) begin
            b_rdata  <= ram_dout;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= ram_dout;
            a_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_ena, ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        preload;
  logic [31:0] mem [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Word i starts out as 0x1000_0000 + i.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      ram_dout <= '0;
    end else if (ram_ena) begin
      if (ram_wena) mem[ram_addr] <= ram_din;
      else          ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Starts on the next IDLE cycle with a single requester and runs the access to completion.
  task automatic op(input logic use_b, input logic we, input logic [4:0] addr,
                    input logic [31:0] wdata, input logic [31:0] exp);
    @(posedge clk); #1;
    if (use_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    @(negedge clk);
    chk("c0_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("issue_gnt", 32'({a_gnt, b_gnt}), use_b ? 32'd1 : 32'd2);
    chk("issue_ena", 32'(ram_ena), 32'd1);
    chk("issue_wena", 32'(ram_wena), 32'(we));
    chk("issue_addr", 32'(ram_addr), 32'(addr));
    if (we) chk("issue_din", ram_din, wdata);
    if (!we) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("read_ena", 32'(ram_ena), 32'd0);
      chk("read_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      chk("read_addr_hold", 32'(ram_addr), 32'(addr));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid", 32'({a_rvalid, b_rvalid}), use_b ? 32'd1 : 32'd2);
      chk("rdata", use_b ? b_rdata : a_rdata, exp);
    end
  endtask

  typedef struct {
    logic        use_b;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    int   ngnt;
    logic exp_b;

    vt[0] = '{1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 5'd7,  32'h12345678, 32'h0};
    vt[3] = '{1'b1, 1'b0, 5'd7,  32'h0,        32'h12345678};
    vt[4] = '{1'b0, 1'b0, 5'd31, 32'h0,        32'h1000001F};
    vt[5] = '{1'b1, 1'b1, 5'd0,  32'hAAAA5555, 32'h0};
    vt[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'hAAAA5555};
    vt[7] = '{1'b1, 1'b0, 5'd3,  32'h0,        32'hDEADBEEF};

    rst_n = 1'b0; preload = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_ena", 32'({ram_ena, ram_wena}), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", ram_din, 32'd0);
    chk("rst_ardata", a_rdata, 32'd0);
    chk("rst_brdata", b_rdata, 32'd0);

    // Both requesters hold writes from reset: grants alternate A,B,... every other cycle.
    a_req = 1; a_we = 1; a_addr = 5'd10; a_wdata = 32'hA;
    b_req = 1; b_we = 1; b_addr = 5'd11; b_wdata = 32'hB;
    @(posedge clk); #1 rst_n = 1'b1;
    ngnt = 0; exp_b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rr_exclusive", 32'(a_gnt & b_gnt), 32'd0);
      if (a_gnt || b_gnt) begin
        chk("rr_who", 32'(b_gnt), 32'(exp_b));
        exp_b = ~exp_b;
        ngnt++;
      end
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    chk("rr_count", 32'(ngnt), 32'd8);

    for (int i = 0; i < 8; i++) op(vt[i].use_b, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);

    // B was granted last: A's read of 31 goes first and sees old data, then B's write.
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 5'd31;
    b_req = 1; b_we = 1; b_addr = 5'd31; b_wdata = 32'h1;
    @(posedge clk); #1 a_req = 0;
    @(negedge clk);
    chk("both_gnt", 32'({a_gnt, b_gnt}), 32'd2);
    chk("both_wena", 32'(ram_wena), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("both_rvalid", 32'(a_rvalid), 32'd1);
    chk("both_old", a_rdata, 32'h1000001F);
    @(posedge clk); #1 b_req = 0;
    @(negedge clk);
    chk("both_bgnt", 32'({a_gnt, b_gnt}), 32'd1);
    chk("both_bwena", 32'(ram_wena), 32'd1);
    chk("both_bdin", ram_din, 32'h1);
    chk("both_baddr", 32'(ram_addr), 32'd31);
    op(1'b0, 1'b0, 5'd31, 32'h0, 32'h1);

    // Single-cycle request pulse still completes with exactly one grant.
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 32'h55;
    @(posedge clk); #1 a_req = 0;
    ngnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_gnt) ngnt++;
      @(posedge clk); #1;
    end
    chk("pulse_gnt_count", 32'(ngnt), 32'd1);
    op(1'b0, 1'b0, 5'd5, 32'h0, 32'h55);

    // Reset while A's read is in READ: nothing for it afterwards.
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 5'd3;
    @(posedge clk); #1 a_req = 0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rstrd_ardata", a_rdata, 32'd0);
    chk("rstrd_ena", 32'(ram_ena), 32'd0);
    chk("rstrd_rvalid", 32'(a_rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstrd_quiet", 32'({a_rvalid, ram_ena}), 32'd0);
      @(posedge clk); #1;
    end
    op(1'b0, 1'b0, 5'd3, 32'h0, 32'hDEADBEEF);

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle", 32'({ram_ena, a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 5, address width; DW, 32, data width.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req, b_req  input  1 each  requester A/B access request, held until matching gnt.
REQ-005 a_we, b_we  input  1 each  1=write, 0=read; valid while req high.
REQ-006 a_addr, b_addr  input  AW each  word address.
REQ-007 a_wdata, b_wdata  input  DW each  write data.
REQ-008 a_gnt, b_gnt  output  1 each  one-cycle pulse: request accepted and issued to RAM.
REQ-009 a_rvalid, b_rvalid  output  1 each  one-cycle pulse: read data valid on x_rdata.
REQ-010 a_rdata, b_rdata  output  DW each  last read result per requester, held until next read for that requester.
REQ-011 ram_ena  output  1  RAM enable; ram_wena  output  1  RAM write enable.
REQ-012 ram_addr  output  AW  and ram_din  output  DW  RAM address and write data.
REQ-013 ram_dout  input  DW  RAM registered read data, valid the cycle after a read is issued.

Function
REQ-014 FSM SHALL have states IDLE, ISSUE, READ.
REQ-015 IDLE: if a_req|b_req, winner's we/addr/wdata SHALL be latched and state -> ISSUE; else remain IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester wins; both requesting -> the one not granted last wins.
REQ-017 ISSUE: ram_ena=1, ram_wena=latched we, ram_addr/ram_din=latched values, winner's gnt=1 for exactly this cycle.
REQ-018 ISSUE with write SHALL -> IDLE; ISSUE with read SHALL -> READ.
REQ-019 READ: ram_ena=0; ram_dout SHALL be captured into winner's x_rdata at cycle end; state -> IDLE.
REQ-020 x_rvalid SHALL pulse one cycle, the cycle after READ (first IDLE cycle), with x_rdata holding captured value.
REQ-021 Latency: req seen in IDLE cycle 0 -> gnt cycle 1 -> read data in RAM cycle 2 -> rvalid/rdata cycle 3.
REQ-022 Throughput: write SHALL occupy 2 cycles (IDLE+ISSUE), read 3 cycles (IDLE+ISSUE+READ).
REQ-023 Outside ISSUE, ram_ena, ram_wena SHALL be 0; ram_addr/ram_din SHALL hold last latched values.
REQ-024 Requests SHALL be sampled only in IDLE; req changes in ISSUE/READ SHALL be ignored.
REQ-025 Latched operation SHALL complete even if its req deasserts after latching.
REQ-026 A requester holding req after its gnt SHALL be treated as a new request in the next IDLE.
REQ-027 Never more than one of a_gnt/b_gnt, nor of a_rvalid/b_rvalid, SHALL be high in a cycle.
REQ-028 Address wrap: AW-bit address SHALL pass unmodified; no range check.
REQ-029 ram_dout SHALL be sampled only in READ (RAM output may be high-Z when ram_ena=0).

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, all gnt/rvalid/ram_ena/ram_wena to 0, ram_addr/ram_din/a_rdata/b_rdata to 0.
REQ-031 After reset, round-robin pointer SHALL give A priority (last granted = B).
REQ-032 Reset during ISSUE or READ SHALL abandon the operation; no gnt/rvalid for it afterward.
REQ-033 First arbitration SHALL occur in the first IDLE cycle after rst_n rises.

Verification
REQ-034 A write addr 3 data 0xDEADBEEF, then A read addr 3 -> a_gnt cycle 1, a_rvalid cycle 3 of read, a_rdata=0xDEADBEEF.
REQ-035 A and B both request from reset, held -> grants alternate A,B,A,B; never simultaneous.
REQ-036 B write addr 31 data 0x1, A read addr 31 simultaneously after B last granted -> A granted first, reads old data; B write then; A re-read returns 0x1.
REQ-037 Assert rst_n low during READ of A read -> no a_rvalid, a_rdata=0, ram_ena=0 immediately; next request served normally.
REQ-038 A req pulsed 1 cycle in IDLE, dropped during ISSUE -> op completes, a_gnt pulses once.
REQ-039 No requests 20 cycles -> ram_ena=0 throughout, no gnt/rvalid.
